alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Initiator side of the ALU operand/opcode interface. It accepts tagged ALU commands from an upstream valid/ready port and buffers them in a small FIFO. It drives A/B/Opcode into the ALU one operation at a time, waits the ALU's registered latency, then samples the result. Results return on a downstream valid/ready port, in order, with the originating tag and an illegal-opcode flag.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the command/response tag
ALU_LAT, 1, cycles from the ALU seeing A/B/Opcode until its result is valid (registered ALU = 1)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  4  ALU opcode
cmd_a  in  32  operand A
cmd_b  in  32  operand B
cmd_tag  in  TAG_W  opaque tag, returned with the response
alu_A  out  32  operand A to the ALU
alu_B  out  32  operand B to the ALU
alu_Opcode  out  4  opcode to the ALU
alu_result  in  32  ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_result  out  32  sampled ALU result (0 if rsp_err)
rsp_tag  out  TAG_W  tag of the command
rsp_err  out  1  opcode was illegal and was not issued

Behaviour:
- Interface rule (decided): one clock, clk; reset is synchronous and active-high, named reset.
- Legal opcodes: ADD 4'b0000, SUB 4'b0010, AND 4'b0100, OR 4'b0101, XOR 4'b0110, NOR 4'b0111, SLT 4'b1010. All other codes are illegal.
- Reset: FIFO emptied; state IDLE; rsp_valid=0; rsp_result, rsp_tag, rsp_err, alu_A, alu_B, alu_Opcode all 0.
- cmd_ready = !full && !reset. There is no push-through when full, even if a pop happens in the same cycle. A push is visible to the FSM on the next cycle.
- FIFO pointers use log2(DEPTH)+1 bits and wrap naturally. full/empty are decided by the MSB-difference rule. Push and pop in the same cycle are legal when neither full nor empty applies.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head.
    - Legal opcode: register the head into alu_A/B/Opcode, capture the tag, load the wait counter with ALU_LAT, go to WAIT.
    - Illegal opcode: leave alu_* unchanged, set rsp_err=1, rsp_result=0, go to RESP.
  - WAIT: lasts ALU_LAT+1 cycles. alu_* are held stable. At the edge ending the last WAIT cycle, alu_result is sampled into rsp_result and rsp_err=0; go to RESP.
  - RESP: rsp_valid=1. rsp_result, rsp_tag and rsp_err stay stable until the handshake. On rsp_ready go to IDLE with rsp_valid=0 the next cycle.
- Latency with ALU_LAT=1: a command accepted in cycle 0 into an empty, idle block gives rsp_valid in cycle 4 (ALU_LAT+3).
- Throughput is one operation per ALU_LAT+3 cycles when rsp_ready is held high. Only one operation is in flight at a time.
- Responses are returned strictly in command order.
- After a completed response, alu_* keep their last values.
- Reset asserted in any state drops the in-flight operation and the FIFO contents. No response is ever produced for a dropped command.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT;
  - function op_is_legal(op);
  - FSM state encoding IDLE/WAIT/RESP.
- The same package serves the ALU and the bench.
- One sub-module: alu_cmd_fifo, a synchronous FIFO of width 4+32+32+TAG_W and depth DEPTH, with push/pop/full/empty.

Test Plan:
- ADD A=5, B=3, tag=0x7, accepted in cycle 0 -> rsp_valid in cycle 4 with rsp_result=8, rsp_tag=0x7, rsp_err=0; alu_Opcode=4'b0000 during WAIT.
- SUB A=3, B=5 -> 0xFFFFFFFE; then SLT A=0xFFFFFFFF, B=1 -> 1. Responses arrive in order with tags 1 and 2.
- A=0xF0F0F0F0, B=0xFF00FF00 issued as AND, OR, XOR, NOR back-to-back -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F, in order.
- Opcode 4'b1111, tag=3 -> rsp_err=1, rsp_result=0, rsp_tag=3; alu_A/B/Opcode unchanged from the previous operation.
- Back-to-back cmd_valid with rsp_ready=0 -> the first command reaches RESP and the next DEPTH=4 fill the FIFO. cmd_ready drops while the 6th is presented. rsp_* stay stable; when rsp_ready is raised all 5 responses drain in order.
- Reset pulsed for 1 cycle while in WAIT with 2 entries queued -> rsp_valid stays 0 afterwards. cmd_ready=1 in the first cycle after reset. A fresh ADD 1+1 returns 2 with no stale response before it.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, opcode legality check and issuer FSM state encoding
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } issuer_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with extra-MSB pointers
// Ports: clk, reset (sync, active-high); push/wdata write side; pop/rdata read side
//        (rdata shows the head combinationally); full, empty status.
module alu_cmd_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bit means the writer is a full lap ahead.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full && !reset;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rptr <= rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers tagged ALU commands and issues them one at a time
// Ports: clk, reset (sync, active-high)
//        cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_tag   upstream command port
//        alu_A/alu_B/alu_Opcode -> ALU, alu_result <- ALU (ALU_LAT cycles later)
//        rsp_valid/rsp_ready/rsp_result/rsp_tag/rsp_err    downstream response port
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [3:0]       alu_Opcode,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int FW = 4 + 32 + 32 + TAG_W;
    // Wide enough to hold ALU_LAT, never narrower than 2 bits.
    localparam int CW = $clog2(ALU_LAT + 2) + 1;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_wdata;
    logic [FW-1:0]    fifo_rdata;

    logic [3:0]       head_op;
    logic [31:0]      head_a;
    logic [31:0]      head_b;
    logic [TAG_W-1:0] head_tag;

    issuer_state_t    state, state_d;
    logic [CW-1:0]    wait_cnt, wait_cnt_d;
    logic [31:0]      alu_a_d, alu_b_d;
    logic [3:0]       alu_op_d;
    logic [31:0]      rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_d;
    logic             rsp_err_d;

    // No push-through when full: a same-cycle pop does not open a slot.
    assign cmd_ready  = !fifo_full && !reset;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_op, cmd_a, cmd_b, cmd_tag};
    assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

    alu_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_valid = (state == RESP);

    always_comb begin
        state_d      = state;
        wait_cnt_d   = wait_cnt;
        alu_a_d      = alu_A;
        alu_b_d      = alu_B;
        alu_op_d     = alu_Opcode;
        rsp_result_d = rsp_result;
        rsp_tag_d    = rsp_tag;
        rsp_err_d    = rsp_err;
        fifo_pop     = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    rsp_tag_d = head_tag;
                    if (op_is_legal(head_op)) begin
                        alu_a_d    = head_a;
                        alu_b_d    = head_b;
                        alu_op_d   = head_op;
                        wait_cnt_d = CW'(ALU_LAT);
                        state_d    = WAIT;
                    end else begin
                        // Illegal opcodes never reach the ALU; alu_* keep
                        // the previous operation's values.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        state_d      = RESP;
                    end
                end
            end
            WAIT: begin
                // Counting ALU_LAT down to zero gives ALU_LAT+1 WAIT cycles.
                if (wait_cnt == '0) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    state_d      = RESP;
                end else begin
                    wait_cnt_d = wait_cnt - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_Opcode <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_d;
            wait_cnt   <= wait_cnt_d;
            alu_A      <= alu_a_d;
            alu_B      <= alu_b_d;
            alu_Opcode <= alu_op_d;
            rsp_result <= rsp_result_d;
            rsp_tag    <= rsp_tag_d;
            rsp_err    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer with a registered ALU model
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int ALU_LAT = 1;

    typedef struct packed {
        logic             err;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } rsp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_A;
    logic [31:0]      alu_B;
    logic [3:0]       alu_Opcode;
    logic [31:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    int   checks   = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    rsp_t obs_q[$];
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [3:0]  last_op;
    logic [3:0]  legal_ops [7] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Opcode(alu_Opcode), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    // Registered ALU (latency 1).
    always @(posedge clk) begin
        case (alu_Opcode)
            OP_ADD:  alu_result <= alu_A + alu_B;
            OP_SUB:  alu_result <= alu_A - alu_B;
            OP_AND:  alu_result <= alu_A & alu_B;
            OP_OR:   alu_result <= alu_A | alu_B;
            OP_XOR:  alu_result <= alu_A ^ alu_B;
            OP_NOR:  alu_result <= ~(alu_A | alu_B);
            OP_SLT:  alu_result <= {31'd0, $signed(alu_A) < $signed(alu_B)};
            default: alu_result <= 32'hDEAD_BEEF;
        endcase
    end

    // Every completed response handshake, in arrival order.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            obs_q.push_back({rsp_err, rsp_tag, rsp_result});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic ref_legal(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd2) || (op == 4'd4) || (op == 4'd5) ||
               (op == 4'd6) || (op == 4'd7) || (op == 4'd10);
    endfunction

    function automatic rsp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] tag);
        rsp_t r;
        r.tag = tag;
        r.err = 1'b0;
        case (op)
            4'd0:    r.res = a + b;
            4'd2:    r.res = a - b;
            4'd4:    r.res = a & b;
            4'd5:    r.res = a | b;
            4'd6:    r.res = a ^ b;
            4'd7:    r.res = ~(a | b);
            4'd10:   r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin r.err = 1'b1; r.res = 32'd0; end
        endcase
        return r;
    endfunction

    // Presents one command and returns #1 after the edge that accepted it.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int n = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            checks++; failures++;
            $display("FAIL send_timeout cmd_ready=%0b required=1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (ref_legal(op)) begin
            last_a = a; last_b = b; last_op = op;
        end
    endtask

    task automatic wait_rsp(input int n);
        int c = 0;
        while (obs_q.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        checks++; if (rsp_result !== 32'd0) begin failures++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
        checks++; if (rsp_tag !== '0) begin failures++; $display("FAIL reset_rsp_tag got=%h exp=0", rsp_tag); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%0b exp=0", rsp_err); end
        checks++; if ({alu_A, alu_B, alu_Opcode} !== 68'd0) begin failures++; $display("FAIL reset_alu got A=%h B=%h op=%h exp 0", alu_A, alu_B, alu_Opcode); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready_in_reset got=%0b exp=0", cmd_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready_after got=%0b exp=1", cmd_ready); end
    endtask

    task automatic test_latency;
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(OP_ADD, 32'd5, 32'd3, 4'h7);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) begin
                checks++;
                if (alu_Opcode !== 4'b0000 || alu_A !== 32'd5 || alu_B !== 32'd3) begin
                    failures++;
                    $display("FAIL latency_wait_alu got op=%h A=%h B=%h exp op=0 A=5 B=3", alu_Opcode, alu_A, alu_B);
                end
            end
            checks++;
            if (rsp_valid !== (k == 4)) begin
                failures++;
                $display("FAIL latency_rsp_valid cycle=%0d got=%0b exp=%0b", k, rsp_valid, (k == 4));
            end
        end
        checks++;
        if ({rsp_err, rsp_tag, rsp_result} !== {1'b0, 4'h7, 32'd8}) begin
            failures++;
            $display("FAIL latency_rsp got err=%0b tag=%h res=%h exp err=0 tag=7 res=8", rsp_err, rsp_tag, rsp_result);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL latency_after_handshake got=%0b exp=0", rsp_valid); end
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL latency_rsp_count got=%0d exp=1", obs_q.size()); end
    endtask

    task automatic test_in_order;
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(OP_SUB, 32'd3, 32'd5, 4'd1);          exp_q.push_back({1'b0, 4'd1, 32'hFFFF_FFFE});
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2);  exp_q.push_back({1'b0, 4'd2, 32'h0000_0001});
        send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4); exp_q.push_back({1'b0, 4'd4, 32'hF000_F000});
        send(OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5); exp_q.push_back({1'b0, 4'd5, 32'hFFF0_FFF0});
        send(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6); exp_q.push_back({1'b0, 4'd6, 32'h0FF0_0FF0});
        send(OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7); exp_q.push_back({1'b0, 4'd7, 32'h000F_000F});
        wait_rsp(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL order_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL order_rsp[%0d] got err=%0b tag=%h res=%h exp err=%0b tag=%h res=%h", i,
                             obs_q[i].err, obs_q[i].tag, obs_q[i].res, exp_q[i].err, exp_q[i].tag, exp_q[i].res);
                end
            end
        end
    endtask

    task automatic test_illegal;
        logic [3:0] op;
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 4'd3);
        exp_q.push_back({1'b1, 4'd3, 32'd0});
        for (int i = 0; i < 4; i++) begin
            do op = 4'($urandom_range(0, 15)); while (ref_legal(op));
            send(op, $urandom, $urandom, 4'(8 + i));
            exp_q.push_back({1'b1, 4'(8 + i), 32'd0});
        end
        wait_rsp(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL illegal_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL illegal_rsp[%0d] got err=%0b tag=%h res=%h exp err=%0b tag=%h res=%h", i,
                             obs_q[i].err, obs_q[i].tag, obs_q[i].res, exp_q[i].err, exp_q[i].tag, exp_q[i].res);
                end
            end
        end
        checks++;
        if (alu_A !== last_a || alu_B !== last_b || alu_Opcode !== last_op) begin
            failures++;
            $display("FAIL illegal_alu_held got A=%h B=%h op=%h exp A=%h B=%h op=%h",
                     alu_A, alu_B, alu_Opcode, last_a, last_b, last_op);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  op;
        logic [31:0] a, b;
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = legal_ops[$urandom_range(0, 6)];
            a = $urandom; b = $urandom;
            send(op, a, b, 4'(i + 1));
            exp_q.push_back(model(op, a, b, 4'(i + 1)));
        end
        cmd_op = OP_ADD; cmd_a = 32'd1; cmd_b = 32'd2; cmd_tag = 4'hF; cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_cmd_ready_full cycle=%0d got=%0b exp=0", k, cmd_ready); end
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_tag, rsp_result} !== exp_q[0]) begin
                failures++;
                $display("FAIL b2b_rsp_stable cycle=%0d got v=%0b err=%0b tag=%h res=%h exp v=1 err=%0b tag=%h res=%h", k,
                         rsp_valid, rsp_err, rsp_tag, rsp_result, exp_q[0].err, exp_q[0].tag, exp_q[0].res);
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp(5);
        checks++;
        if (obs_q.size() != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", obs_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b_rsp[%0d] got err=%0b tag=%h res=%h exp err=%0b tag=%h res=%h", i,
                             obs_q[i].err, obs_q[i].tag, obs_q[i].res, exp_q[i].err, exp_q[i].tag, exp_q[i].res);
                end
            end
        end
    endtask

    task automatic test_reset_midflight;
        bit seen_valid = 1'b0;
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(legal_ops[$urandom_range(0, 6)], $urandom, $urandom, 4'(i + 1));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midreset_cmd_ready got=%0b exp=1", cmd_ready); end
        checks++; if (alu_A !== 32'd0 || alu_Opcode !== 4'd0) begin failures++; $display("FAIL midreset_alu got A=%h op=%h exp 0", alu_A, alu_Opcode); end
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid !== 1'b0) seen_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_valid || obs_q.size() != 0) begin failures++; $display("FAIL midreset_stale_rsp got responses=%0d valid_seen=%0b exp 0", obs_q.size(), seen_valid); end
        @(posedge clk); #1;
        send(OP_ADD, 32'd1, 32'd1, 4'd9);
        exp_q.push_back({1'b0, 4'd9, 32'd2});
        wait_rsp(1);
        repeat (6) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin failures++; $display("FAIL midreset_count got=%0d exp=1", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                failures++;
                $display("FAIL midreset_fresh_add got err=%0b tag=%h res=%h exp err=0 tag=9 res=2",
                         obs_q[0].err, obs_q[0].tag, obs_q[0].res);
            end
        end
    endtask

    task automatic test_random;
        bit done = 1'b0;
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        fork
            begin
                logic [3:0]  op;
                logic [31:0] a, b;
                for (int i = 0; i < 40; i++) begin
                    op = 4'($urandom_range(0, 15));
                    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                    send(op, a, b, 4'(i));
                    exp_q.push_back(model(op, a, b, 4'(i)));
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_rsp(40);
        checks++;
        if (obs_q.size() != 40) begin failures++; $display("FAIL random_count got=%0d exp=40", obs_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_rsp[%0d] got err=%0b tag=%h res=%h exp err=%0b tag=%h res=%h", i,
                             obs_q[i].err, obs_q[i].tag, obs_q[i].res, exp_q[i].err, exp_q[i].tag, exp_q[i].res);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_in_order();
        test_illegal();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
